neuron_unit: RTL and testbench

//  Fixed-point single-layer classifier over a 7x7 luminance window.

---
 rtl/neuron_unit.sv | 86 ++++++++
 tb/tb_neuron_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/neuron_unit.sv
// neuron_unit: four-neuron fixed-point classifier over a 7x7 window.
// Three register stages: window capture, weighted sum, bias/shift/ReLU/saturate.
module neuron_unit #(
    parameter logic [1567:0] WEIGHTS = {196{8'sd1}},
    parameter logic [127:0]  BIASES  = '0,
    parameter int            SHIFT   = 0,
    parameter int            RELU    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               de_in,
    input  logic [55:0]        line_0_in,
    input  logic [55:0]        line_1_in,
    input  logic [55:0]        line_2_in,
    input  logic [55:0]        line_3_in,
    input  logic [55:0]        line_4_in,
    input  logic [55:0]        line_5_in,
    input  logic [55:0]        line_6_in,
    output logic signed [31:0] symbol_0,
    output logic signed [31:0] symbol_1,
    output logic signed [31:0] symbol_2,
    output logic signed [31:0] symbol_3
);
    logic [55:0]        lines [7];
    logic [7:0]         pix   [49];
    logic               v1, v2;
    logic signed [23:0] acc   [4];
    logic signed [23:0] acc_d [4];
    logic signed [33:0] sum   [4];
    logic signed [33:0] sh    [4];
    logic signed [33:0] rl    [4];
    logic signed [31:0] sym   [4];
    logic signed [31:0] sym_d [4];
    assign lines = '{line_0_in, line_1_in, line_2_in, line_3_in, line_4_in, line_5_in, line_6_in};
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            for (int i = 0; i < 49; i++) pix[i] <= '0;
        end else begin
            v1 <= de_in;
            if (de_in)
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++)
                        pix[r*7+c] <= lines[r][55-8*c -: 8];
        end
    end
    // Modulo-2^24 products of zero-extended pixels and sign-extended weights give the exact signed sum.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            acc_d[k] = '0;
            for (int i = 0; i < 49; i++)
                acc_d[k] = acc_d[k] + {16'b0, pix[i]} *
                           {{16{WEIGHTS[(k*49+i)*8+7]}}, WEIGHTS[(k*49+i)*8 +: 8]};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            v2 <= v1;
            if (v1)
                for (int k = 0; k < 4; k++) acc[k] <= acc_d[k];
        end
    end
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum[k]   = {{10{acc[k][23]}}, acc[k]} + {{2{BIASES[k*32+31]}}, BIASES[k*32 +: 32]};
            sh[k]    = sum[k] >>> SHIFT;
            rl[k]    = (RELU != 0 && sh[k] < 0) ? '0 : sh[k];
            sym_d[k] = (rl[k][33:31] == 3'b000 || rl[k][33:31] == 3'b111) ? rl[k][31:0] :
                       rl[k][33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) sym[k] <= '0;
        end else if (v2) begin
            for (int k = 0; k < 4; k++) sym[k] <= sym_d[k];
        end
    end
    assign symbol_0 = sym[0];
    assign symbol_1 = sym[1];
    assign symbol_2 = sym[2];
    assign symbol_3 = sym[3];
endmodule

// File: tb/tb_neuron_unit.sv
// tb_neuron_unit: six differently configured neuron_unit instances share one stimulus stream;
// a reference model fills a scoreboard queue and a negedge monitor checks every output each cycle.
module tb_neuron_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        de;
    logic [55:0] ln [7];
    logic [31:0] so [6][4];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [1567:0] w_neg0();
        logic [1567:0] w;
        for (int i = 0; i < 196; i++) w[i*8 +: 8] = (i < 49) ? 8'hFF : 8'h01;
        return w;
    endfunction

    function automatic logic [1567:0] w_rand(int unsigned seed);
        logic [1567:0] w;
        int unsigned   s;
        s = seed * 32'd2654435761 + 32'd1;
        for (int i = 0; i < 196; i++) begin
            s = s * 32'd1664525 + 32'd1013904223;
            w[i*8 +: 8] = s[31:24];
        end
        return w;
    endfunction

    function automatic logic [1567:0] cfg_w(int g);
        return (g == 0) ? {196{8'sd1}} : (g < 4) ? w_neg0() : w_rand(g);
    endfunction

    function automatic logic [127:0] cfg_b(int g);
        return (g == 3) ? {32'sd5, 32'h7FFF_FFF0, -32'sd100, 32'h8000_0010} :
               (g >= 4) ? {32'sd1000, -32'sd5000, 32'sd77, -32'sd1} : 128'd0;
    endfunction

    function automatic int cfg_s(int g);
        return (g == 4) ? 3 : (g == 5) ? 5 : 0;
    endfunction

    function automatic int cfg_r(int g);
        return (g == 2 || g == 3 || g == 5) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_dut
        neuron_unit #(
            .WEIGHTS(cfg_w(g)), .BIASES(cfg_b(g)), .SHIFT(cfg_s(g)), .RELU(cfg_r(g))
        ) u_dut (
            .clk(clk), .reset(reset), .de_in(de),
            .line_0_in(ln[0]), .line_1_in(ln[1]), .line_2_in(ln[2]), .line_3_in(ln[3]),
            .line_4_in(ln[4]), .line_5_in(ln[5]), .line_6_in(ln[6]),
            .symbol_0(so[g][0]), .symbol_1(so[g][1]), .symbol_2(so[g][2]), .symbol_3(so[g][3])
        );
    end

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic straight from the scoring rules.
    function automatic logic [127:0] model(int g, logic [391:0] win);
        logic [1567:0] w;
        logic [127:0]  b, r;
        longint        acc, t, bias;
        int            px, wt;
        w = cfg_w(g);
        b = cfg_b(g);
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int i = 0; i < 49; i++) begin
                px = win[391-8*i -: 8];
                wt = $signed(w[(k*49+i)*8 +: 8]);
                acc += px * wt;
            end
            bias = $signed(b[k*32 +: 32]);
            t = (acc + bias) >>> cfg_s(g);
            if (cfg_r(g) != 0 && t < 0) t = 0;
            if (t > 64'sd2147483647) t = 64'sd2147483647;
            if (t < -64'sd2147483648) t = -64'sd2147483648;
            r[k*32 +: 32] = t[31:0];
        end
        return r;
    endfunction

    logic [767:0] q [$];
    logic [767:0] last = '0;
    logic [2:0]   vq = '0;
    logic         rst_q = 1'b0;

    always @(posedge clk) begin
        logic [767:0] e;
        rst_q <= reset;
        vq <= reset ? 3'b000 : {vq[1:0], de};
        if (!reset && de) begin
            for (int g = 0; g < 6; g++)
                e[g*128 +: 128] = model(g, {ln[0], ln[1], ln[2], ln[3], ln[4], ln[5], ln[6]});
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            q.delete();
            last = '0;
        end else if (vq[2]) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow got empty queue required an expected entry");
            end else begin
                last = q.pop_front();
            end
        end
        for (int g = 0; g < 6; g++)
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (so[g][k] !== last[g*128 + k*32 +: 32]) begin
                    n_err++;
                    $display("FAIL dut%0d.symbol_%0d got %0d required %0d", g, k,
                             $signed(so[g][k]), $signed(last[g*128 + k*32 +: 32]));
                end
            end
    end

    function automatic logic [391:0] fill(logic [7:0] v);
        return {49{v}};
    endfunction

    task automatic drive(input logic d, input logic [391:0] w);
        de = d;
        for (int r = 0; r < 7; r++) ln[r] = w[391-56*r -: 56];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [391:0] p33;
        logic [415:0] tmp;
        int           m;
        reset = 1'b1;
        de = 1'b0;
        for (int r = 0; r < 7; r++) ln[r] = '0;
        drive(1'b1, '0);
        repeat (3) drive(1'b1, fill(8'hAB));
        reset = 1'b0;
        drive(1'b1, fill(8'hFF));
        repeat (4) drive(1'b0, fill(8'h55));
        p33 = '0;
        p33[391-8*24 -: 8] = 8'd200;
        drive(1'b1, p33);
        repeat (4) drive(1'b0, '0);
        drive(1'b1, fill(8'd10));
        repeat (4) drive(1'b0, '0);
        drive(1'b1, fill(8'd1));
        drive(1'b1, fill(8'd2));
        repeat (4) drive(1'b0, '0);
        drive(1'b1, fill(8'd1));
        drive(1'b1, fill(8'd2));
        reset = 1'b1;
        drive(1'b0, '0);
        reset = 1'b0;
        repeat (4) drive(1'b0, '0);
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom % 64) == 0;
            for (int j = 0; j < 13; j++) tmp[j*32 +: 32] = $urandom;
            m = $urandom % 8;
            drive(($urandom % 4) != 0, (m == 0) ? '0 : (m == 1) ? fill(8'hFF) :
                  (m == 2) ? fill(8'($urandom)) : tmp[391:0]);
        end
        reset = 1'b0;
        repeat (6) drive(1'b0, '0);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d entries left required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
